config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 114 +++++++++++
 tb/tb_config_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Function : Serialises bitstream words MSB-first into a tile configuration
//            shift chain, emitting exactly CHAIN_LENGTH chain enables per load.
// Revision : 1.0 - initial release
// ============================================================================
module config_loader #(
   parameter int CHAIN_LENGTH = 384,
   parameter int WORD_WIDTH   = 32
) (
   input  logic                  config_clock,
   input  logic                  config_nreset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  chain_data,
   output logic                  chain_enable,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           bits_remaining
);

   localparam int                 c_CNT_W     = $clog2(WORD_WIDTH + 1);
   localparam logic [15:0]        c_CHAIN_LEN = 16'(CHAIN_LENGTH);
   localparam logic [15:0]        c_WORD_W16  = 16'(WORD_WIDTH);
   localparam logic [c_CNT_W-1:0] c_WORD_CNT  = c_CNT_W'(WORD_WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [WORD_WIDTH-1:0] r_shift;
   logic [WORD_WIDTH-1:0] w_shift_nxt;
   logic [c_CNT_W-1:0]    r_word_cnt;
   logic [c_CNT_W-1:0]    w_word_cnt_nxt;
   logic [15:0]           r_bits_rem;
   logic [15:0]           w_bits_rem_nxt;

   always_ff @(posedge config_clock) begin
      if (!config_nreset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_word_cnt <= '0;
         r_bits_rem <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_word_cnt <= w_word_cnt_nxt;
         r_bits_rem <= w_bits_rem_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_word_cnt_nxt = r_word_cnt;
      w_bits_rem_nxt = r_bits_rem;
      word_ready     = 1'b0;
      chain_data     = 1'b0;
      chain_enable   = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            done = (r_state == ST_DONE);
            if (start) begin
               w_state_nxt    = ST_LOAD;
               w_bits_rem_nxt = c_CHAIN_LEN;
            end
         end

         ST_LOAD: begin
            word_ready = 1'b1;
            busy       = 1'b1;
            if (word_valid) begin
               w_shift_nxt = word_data;
               // A short final word keeps only its top bits; the rest fall off the left.
               w_word_cnt_nxt = (r_bits_rem < c_WORD_W16) ? r_bits_rem[c_CNT_W-1:0]
                                                           : c_WORD_CNT;
               w_state_nxt    = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            busy           = 1'b1;
            chain_enable   = 1'b1;
            chain_data     = r_shift[WORD_WIDTH-1];
            w_shift_nxt    = {r_shift[WORD_WIDTH-2:0], 1'b0};
            w_word_cnt_nxt = r_word_cnt - c_CNT_ONE;
            w_bits_rem_nxt = r_bits_rem - 16'd1;
            if (r_word_cnt == c_CNT_ONE) begin
               w_state_nxt = (r_bits_rem == 16'd1) ? ST_DONE : ST_LOAD;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bits_remaining = r_bits_rem;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_loader
// Function : Scoreboard bench for config_loader (24-bit and 20-bit chains).
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_loader;

   localparam int WW = 8;

   logic          clk = 1'b0;
   logic          nreset;
   logic [1:0]    start_v;
   logic [1:0]    valid_v;
   logic [WW-1:0] data_v [2];
   logic [1:0]    ready_v;
   logic [1:0]    cdata_v;
   logic [1:0]    cen_v;
   logic [1:0]    busy_v;
   logic [1:0]    done_v;
   logic [15:0]   rem_v [2];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          q0[$];
   bit          q1[$];
   logic [23:0] chain0 = '0;
   logic [19:0] chain1 = '0;
   int          en_cnt [2] = '{0, 0};
   int          rem_m [2] = '{0, 0};
   int          chain_len [2] = '{24, 20};
   int          t0;
   int          t1;

   always #5 clk = ~clk;

   config_loader #(.CHAIN_LENGTH(24), .WORD_WIDTH(WW)) dut0 (
      .config_clock  (clk),
      .config_nreset (nreset),
      .start         (start_v[0]),
      .word_data     (data_v[0]),
      .word_valid    (valid_v[0]),
      .word_ready    (ready_v[0]),
      .chain_data    (cdata_v[0]),
      .chain_enable  (cen_v[0]),
      .busy          (busy_v[0]),
      .done          (done_v[0]),
      .bits_remaining(rem_v[0])
   );

   config_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(WW)) dut1 (
      .config_clock  (clk),
      .config_nreset (nreset),
      .start         (start_v[1]),
      .word_data     (data_v[1]),
      .word_valid    (valid_v[1]),
      .word_ready    (ready_v[1]),
      .chain_data    (cdata_v[1]),
      .chain_enable  (cen_v[1]),
      .busy          (busy_v[1]),
      .done          (done_v[1]),
      .bits_remaining(rem_v[1])
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Chain model plus scoreboard pop on every enabled cycle.
   always @(negedge clk) begin
      bit b;
      if (cen_v[0]) begin
         if (q0.size() == 0) check("sb0_unexpected_shift", cen_v[0], 0);
         else begin
            b = q0.pop_front();
            check("sb0_bit", cdata_v[0], b);
         end
         chain0 = {chain0[22:0], cdata_v[0]};
         en_cnt[0]++;
      end else begin
         check("sb0_data_when_idle", cdata_v[0], 0);
      end
      if (cen_v[1]) begin
         if (q1.size() == 0) check("sb1_unexpected_shift", cen_v[1], 0);
         else begin
            b = q1.pop_front();
            check("sb1_bit", cdata_v[1], b);
         end
         chain1 = {chain1[18:0], cdata_v[1]};
         en_cnt[1]++;
      end else begin
         check("sb1_data_when_idle", cdata_v[1], 0);
      end
   end

   task automatic begin_load(input int sel, output int t_start);
      en_cnt[sel] = 0;
      rem_m[sel]  = chain_len[sel];
      if (sel == 0) begin
         chain0 = '0;
         q0.delete();
      end else begin
         chain1 = '0;
         q1.delete();
      end
      start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
      t_start = cyc;
   endtask

   task automatic send(input int sel, input logic [WW-1:0] w, input int gap);
      int n;
      bit ok;
      ok = 1'b0;
      if (gap > 0) begin
         valid_v[sel] = 1'b0;
         for (int t = 0; t < 100 && !ready_v[sel]; t++) @(negedge clk);
         check("gap_ready_wait", ready_v[sel], 1);
         for (int g = 0; g < gap; g++) begin
            check("gap_ready", ready_v[sel], 1);
            check("gap_enable", cen_v[sel], 0);
            @(negedge clk);
         end
      end
      valid_v[sel] = 1'b1;
      data_v[sel]  = w;
      for (int t = 0; t < 100; t++) begin
         if (ready_v[sel]) begin
            n = (rem_m[sel] < WW) ? rem_m[sel] : WW;
            for (int i = 0; i < n; i++) begin
               if (sel == 0) q0.push_back(w[WW-1-i]);
               else          q1.push_back(w[WW-1-i]);
            end
            rem_m[sel] -= n;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("handshake_seen", ok, 1);
      @(negedge clk);
      valid_v[sel] = 1'b0;
   endtask

   task automatic wait_done(input int sel, output int t_end);
      for (int t = 0; t < 300 && !done_v[sel]; t++) @(negedge clk);
      check("done_reached", done_v[sel], 1);
      t_end = cyc;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, ready_v[0], 0);
      check({tag, "_cdata"}, cdata_v[0], 0);
      check({tag, "_cen"}, cen_v[0], 0);
      check({tag, "_busy"}, busy_v[0], 0);
      check({tag, "_done"}, done_v[0], 0);
      check({tag, "_rem"}, rem_v[0], 0);
   endtask

   initial begin
      nreset    = 1'b0;
      start_v   = '0;
      valid_v   = '0;
      data_v[0] = '0;
      data_v[1] = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      check("reset_busy1", busy_v[1], 0);
      check("reset_rem1", rem_v[1], 0);
      nreset = 1'b1;

      // Words offered in IDLE must be ignored
      valid_v[0] = 1'b1;
      data_v[0]  = 8'hFF;
      repeat (3) @(negedge clk);
      check("idle_busy", busy_v[0], 0);
      check("idle_ready", ready_v[0], 0);
      check("idle_rem", rem_v[0], 0);
      check("idle_cen", cen_v[0], 0);
      valid_v[0] = 1'b0;

      // Back-to-back load, 24-bit chain
      begin_load(0, t0);
      send(0, 8'hA5, 0);
      send(0, 8'h3C, 0);
      send(0, 8'h0F, 0);
      wait_done(0, t1);
      check("run1_cycles", t1 - t0, 27);
      check("run1_enables", en_cnt[0], 24);
      check("run1_chain", chain0, 24'hA53C0F);
      check("run1_busy", busy_v[0], 0);
      check("run1_rem", rem_v[0], 0);
      check("run1_sb_empty", q0.size(), 0);

      // Words offered in DONE must be ignored and done must hold
      valid_v[0] = 1'b1;
      data_v[0]  = 8'h55;
      repeat (2) @(negedge clk);
      check("done_hold", done_v[0], 1);
      check("done_ready", ready_v[0], 0);
      check("done_cen", cen_v[0], 0);
      valid_v[0] = 1'b0;

      // Restart from DONE, start pulse during SHIFT, 5-cycle valid gap
      begin_load(0, t0);
      check("restart_done", done_v[0], 0);
      check("restart_rem", rem_v[0], 24);
      check("restart_busy", busy_v[0], 1);
      check("restart_ready", ready_v[0], 1);
      send(0, 8'hA5, 0);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("shift_start_rem", rem_v[0], 23);
      check("shift_start_cen", cen_v[0], 1);
      check("shift_start_ready", ready_v[0], 0);
      send(0, 8'h3C, 5);
      send(0, 8'h0F, 0);
      wait_done(0, t1);
      check("run2_cycles", t1 - t0, 32);
      check("run2_enables", en_cnt[0], 24);
      check("run2_chain", chain0, 24'hA53C0F);
      check("run2_sb_empty", q0.size(), 0);

      // Reset mid-way through the second word, then a clean reload
      begin_load(0, t0);
      send(0, 8'hA5, 0);
      send(0, 8'h3C, 0);
      repeat (3) @(negedge clk);
      nreset = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      check_reset_outputs("midreset");
      q0.delete();
      begin_load(0, t0);
      send(0, 8'hA5, 0);
      send(0, 8'h3C, 0);
      send(0, 8'h0F, 0);
      wait_done(0, t1);
      check("run3_enables", en_cnt[0], 24);
      check("run3_chain", chain0, 24'hA53C0F);
      check("run3_sb_empty", q0.size(), 0);

      // 20-bit chain: last word truncated to its top 4 bits
      begin_load(1, t0);
      send(1, 8'hA5, 0);
      send(1, 8'h3C, 0);
      send(1, 8'hF7, 0);
      wait_done(1, t1);
      check("run4_cycles", t1 - t0, 23);
      check("run4_enables", en_cnt[1], 20);
      check("run4_chain", chain1, 20'hA53CF);
      check("run4_rem", rem_v[1], 0);
      check("run4_sb_empty", q1.size(), 0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
